// File: rtl/usb_rx_pkg.sv
// Shared encodings and constants for the full-speed USB receive front-end.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2,
    LS_SE1 = 2'd3
  } line_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP
  } rx_state_e;

  localparam int unsigned HIST_W = 8;
  localparam int unsigned ONES_W = 3;
  localparam int unsigned EOP_W  = 2;

  // SYNC symbols K J K J K J K K, oldest in the MSB, 1 = K
  localparam logic [HIST_W-1:0] SYNC_HIST   = 8'b1010_1011;
  localparam logic [ONES_W-1:0] MAX_ONES    = ONES_W'(6);
  localparam logic [EOP_W-1:0]  EOP_SE0_MAX = EOP_W'(3);

  function automatic logic is_data_sym(input line_state_e s);
    return (s == LS_J) || (s == LS_K);
  endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// Line synchroniser, registered line state and 4x-oversampling bit-timing recovery.
module usb_rx_dpll
  import usb_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dp_i,
  input  logic       dn_i,
  output logic [1:0] line_state_o,
  output logic       sample_en_o
);

  localparam int unsigned SW = SYNC_STAGES;

  logic [SW-1:0] dp_sync_q;
  logic [SW-1:0] dn_sync_q;
  logic [1:0]    line_q;
  logic [1:0]    line_d;
  logic [1:0]    phase_q;
  logic [1:0]    phase_d;
  logic          sample_q;

  assign line_d = {dn_sync_q[SW-1], dp_sync_q[SW-1]};

  // Re-centre the sampling phase whenever the registered line state is about to change
  assign phase_d = (line_d != line_q) ? 2'd0 : phase_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_sync_q <= '1;
      dn_sync_q <= '0;
      line_q    <= LS_J;
      phase_q   <= 2'd0;
      sample_q  <= 1'b0;
    end else begin
      dp_sync_q <= {dp_sync_q[SW-2:0], dp_i};
      dn_sync_q <= {dn_sync_q[SW-2:0], dn_i};
      line_q    <= line_d;
      phase_q   <= phase_d;
      sample_q  <= (phase_d == 2'd2);
    end
  end

  assign line_state_o = line_q;
  assign sample_en_o  = sample_q;

endmodule

// File: rtl/usb_fs_rx_frontend.sv
// Full-speed USB RX front-end: SYNC/EOP detection, NRZI decode and bit unstuffing.
// Define USB_RX_BUS_RESET_EN to build the SE0 bus-reset detector; otherwise bus_reset is tied low.
module usb_fs_rx_frontend
  import usb_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned BUS_RESET_CYCLES = 120
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  output logic [1:0] line_state,
  output logic       bit_strobe,
  output logic       bit_data,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       rx_err,
  output logic       bus_reset
);

  logic              sample_en;
  line_state_e       sym;
  rx_state_e         state_q, state_d;
  logic [HIST_W-1:0] hist_q, hist_d, hist_shift_c;
  logic              prev_k_q, prev_k_d;
  logic [ONES_W-1:0] ones_q, ones_d;
  logic [EOP_W-1:0]  eop_q, eop_d;
  logic              strobe_d, data_d, start_d, end_d, err_d;
  logic              same_c;
  logic              br_hit_c;
  logic              bus_reset_d;

  usb_rx_dpll #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_dpll (
    .clk          (clk_48mhz),
    .rst_n        (reset_n),
    .dp_i         (usb_p_rx),
    .dn_i         (usb_n_rx),
    .line_state_o (line_state),
    .sample_en_o  (sample_en)
  );

  assign sym          = line_state_e'(line_state);
  assign hist_shift_c = {hist_q[HIST_W-2:0], (sym == LS_K)};
  assign same_c       = ((sym == LS_K) == prev_k_q);

`ifdef USB_RX_BUS_RESET_EN
  localparam int unsigned BR_W = $clog2(BUS_RESET_CYCLES + 1);
  localparam logic [BR_W-1:0] BR_MAX = BR_W'(BUS_RESET_CYCLES);

  logic [BR_W-1:0] br_cnt_q, br_cnt_d;

  // Saturating count of consecutive SE0 clocks
  always_comb begin
    br_cnt_d = '0;
    if (sym == LS_SE0) begin
      br_cnt_d = (br_cnt_q == BR_MAX) ? br_cnt_q : br_cnt_q + BR_W'(1);
    end
  end

  assign bus_reset_d = (br_cnt_d >= BR_MAX);
  assign br_hit_c    = (br_cnt_d == BR_MAX) && (br_cnt_q != BR_MAX);

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) br_cnt_q <= '0;
    else          br_cnt_q <= br_cnt_d;
  end
`else
  logic unused_bus_reset_cycles;
  assign unused_bus_reset_cycles = ^32'(BUS_RESET_CYCLES);
  assign bus_reset_d = 1'b0;
  assign br_hit_c    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    prev_k_d = prev_k_q;
    ones_d   = ones_q;
    eop_d    = eop_q;
    strobe_d = 1'b0;
    data_d   = 1'b0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_en) begin
          if (!is_data_sym(sym)) begin
            hist_d = '0;
          end else if (hist_shift_c == SYNC_HIST) begin
            hist_d   = '0;
            start_d  = 1'b1;
            prev_k_d = 1'b1;
            ones_d   = '0;
            state_d  = ST_SYNC;
          end else begin
            hist_d = hist_shift_c;
          end
        end
      end
      ST_SYNC: state_d = ST_DATA;
      ST_DATA: begin
        if (sample_en) begin
          case (sym)
            LS_J, LS_K: begin
              prev_k_d = (sym == LS_K);
              if (same_c && (ones_q == MAX_ONES)) begin
                end_d   = 1'b1;
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end else if (same_c) begin
                ones_d   = ones_q + ONES_W'(1);
                strobe_d = 1'b1;
                data_d   = 1'b1;
              end else begin
                // A transition after six ones is a stuffed bit and carries no data
                ones_d   = '0;
                strobe_d = (ones_q != MAX_ONES);
              end
            end
            LS_SE0: begin
              eop_d   = EOP_W'(1);
              state_d = ST_EOP;
            end
            default: begin
              end_d   = 1'b1;
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
      end
      ST_EOP: begin
        if (sample_en) begin
          if (sym != LS_SE0) begin
            end_d   = 1'b1;
            err_d   = (sym != LS_J);
            state_d = ST_IDLE;
          end else if (eop_q == EOP_SE0_MAX) begin
            end_d   = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            eop_d = eop_q + EOP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (br_hit_c && ((state_q == ST_DATA) || (state_q == ST_EOP))) begin
      strobe_d = 1'b0;
      data_d   = 1'b0;
      end_d    = 1'b1;
      err_d    = 1'b1;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hist_q     <= '0;
      prev_k_q   <= 1'b0;
      ones_q     <= '0;
      eop_q      <= '0;
      bit_strobe <= 1'b0;
      bit_data   <= 1'b0;
      pkt_start  <= 1'b0;
      pkt_end    <= 1'b0;
      rx_err     <= 1'b0;
      bus_reset  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      prev_k_q   <= prev_k_d;
      ones_q     <= ones_d;
      eop_q      <= eop_d;
      bit_strobe <= strobe_d;
      bit_data   <= data_d;
      pkt_start  <= start_d;
      pkt_end    <= end_d;
      rx_err     <= err_d;
      bus_reset  <= bus_reset_d;
    end
  end

endmodule

// File: tb/tb_usb_fs_rx_frontend.sv
// Randomised self-checking bench for usb_fs_rx_frontend against a bit-level packet model.
module tb_usb_fs_rx_frontend;

  localparam logic [1:0] SE0 = 2'd0;
  localparam logic [1:0] J   = 2'd1;
  localparam logic [1:0] K   = 2'd2;

  logic       clk_48mhz = 1'b0;
  logic       reset_n   = 1'b1;
  logic       usb_p_rx  = 1'b1;
  logic       usb_n_rx  = 1'b0;
  logic [1:0] line_state;
  logic       bit_strobe, bit_data, pkt_start, pkt_end, rx_err, bus_reset;

  usb_fs_rx_frontend dut (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .usb_p_rx  (usb_p_rx),
    .usb_n_rx  (usb_n_rx),
    .line_state(line_state),
    .bit_strobe(bit_strobe),
    .bit_data  (bit_data),
    .pkt_start (pkt_start),
    .pkt_end   (pkt_end),
    .rx_err    (rx_err),
    .bus_reset (bus_reset)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling edge
  bit got_bits[$];
  int n_start = 0;
  int n_end   = 0;
  int n_err   = 0;

  always @(negedge clk_48mhz) begin
    if (reset_n) begin
      if (bit_strobe) begin
        got_bits.push_back(bit_data);
        check_eq("strobe_overlap", {29'd0, pkt_start, pkt_end, rx_err}, 32'd0);
      end
      if (pkt_start) n_start++;
      if (pkt_end) n_end++;
      if (rx_err) begin
        n_err++;
        check_eq("err_without_end", {31'd0, pkt_end}, 32'd1);
      end
    end
  end

  int jit_mode = 0;
  bit jit_ph   = 1'b0;

  function automatic int next_dur();
    if (jit_mode == 0) return 4;
    jit_ph = !jit_ph;
    return jit_ph ? 5 : 3;
  endfunction

  task automatic drive(input logic [1:0] s);
    int d;
    d = next_dur();
    {usb_n_rx, usb_p_rx} = s;
    repeat (d) @(posedge clk_48mhz);
    #1;
  endtask

  task automatic idle(input int n);
    {usb_n_rx, usb_p_rx} = J;
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask

  // Transmitter: SYNC, NRZI with stuffing for bits below raw_from, then SE0 SE0 J
  task automatic send_pkt(input bit bits[$], input int raw_from, input int abort_at);
    logic [7:0] sp;
    bit cur_k;
    int run;
    sp = 8'b1010_1011;
    idle(12);
    for (int i = 0; i < 8; i++) drive(sp[7-i] ? K : J);
    cur_k = 1'b1;
    run   = 0;
    for (int i = 0; i < bits.size(); i++) begin
      if (i == abort_at) begin
        int e0;
        e0 = n_end;
        reset_n = 1'b0;
        #1;
        check_eq("rst.line_state", {30'd0, line_state}, 32'd1);
        check_eq("rst.bit_strobe", {31'd0, bit_strobe}, 32'd0);
        check_eq("rst.bit_data", {31'd0, bit_data}, 32'd0);
        check_eq("rst.pkt_end", {31'd0, pkt_end}, 32'd0);
        check_eq("rst.rx_err", {31'd0, rx_err}, 32'd0);
        idle(4);
        reset_n = 1'b1;
        idle(24);
        check_eq("rst.no_pkt_end", n_end - e0, 32'd0);
        return;
      end
      if (!bits[i]) cur_k = !cur_k;
      drive(cur_k ? K : J);
      run = bits[i] ? run + 1 : 0;
      if (run == 6 && i < raw_from) begin
        cur_k = !cur_k;
        drive(cur_k ? K : J);
        run = 0;
      end
    end
    drive(SE0);
    drive(SE0);
    drive(J);
    idle(16);
  endtask

  // Receiver model: payload bits come back; a seventh consecutive one on the wire aborts
  task automatic run_pkt(input bit bits[$], input int raw_from, input string tag);
    bit exp_q[$];
    bit exp_err;
    int run, s0, e0, r0, n;
    run = 0;
    exp_err = 1'b0;
    for (int i = 0; i < bits.size(); i++) begin
      if (bits[i]) begin
        if (run == 6) begin
          exp_err = 1'b1;
          break;
        end
        run++;
        exp_q.push_back(1'b1);
      end else begin
        run = 0;
        exp_q.push_back(1'b0);
      end
      if (run == 6 && i < raw_from) run = 0;
    end
    s0 = n_start; e0 = n_end; r0 = n_err;
    got_bits.delete();
    send_pkt(bits, raw_from, -1);
    check_eq({tag, ".start"}, n_start - s0, 32'd1);
    check_eq({tag, ".end"}, n_end - e0, 32'd1);
    check_eq({tag, ".err"}, n_err - r0, {31'd0, exp_err});
    check_eq({tag, ".nbits"}, got_bits.size(), exp_q.size());
    n = (got_bits.size() < exp_q.size()) ? got_bits.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, ".bit"}, {31'd0, got_bits[i]}, {31'd0, exp_q[i]});
  endtask

  task automatic rand_bits(input int len, output bit q[$]);
    q.delete();
    for (int i = 0; i < len; i++) q.push_back(bit'($urandom_range(0, 1)));
  endtask

  initial begin
    bit q[$];
    int s0, plen;
    logic exp_br;

    #5 reset_n = 1'b0;
    repeat (3) @(posedge clk_48mhz);
    #1;
    check_eq("reset.line_state", {30'd0, line_state}, 32'd1);
    check_eq("reset.bit_strobe", {31'd0, bit_strobe}, 32'd0);
    check_eq("reset.pkt_start", {31'd0, pkt_start}, 32'd0);
    check_eq("reset.pkt_end", {31'd0, pkt_end}, 32'd0);
    check_eq("reset.rx_err", {31'd0, rx_err}, 32'd0);
    check_eq("reset.bus_reset", {31'd0, bus_reset}, 32'd0);
    reset_n = 1'b1;
    idle(4);

    jit_mode = 0;
    q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_pkt(q, 8, "byte_a5");
    q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_pkt(q, 8, "byte_ff");
    q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run_pkt(q, 3, "seven_ones");
    rand_bits(12, q);
    run_pkt(q, 12, "after_err");

    jit_mode = 1;
    jit_ph   = 1'b0;
    rand_bits(16, q);
    run_pkt(q, 16, "jitter16");

    for (int p = 0; p < 24; p++) begin
      jit_mode = int'($urandom_range(0, 1));
      jit_ph   = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        plen = int'($urandom_range(1, 10));
        rand_bits(plen, q);
        q[plen-1] = 1'b0;
        for (int i = 0; i < 7; i++) q.push_back(1'b1);
        run_pkt(q, plen, "rand_err");
      end else begin
        plen = int'($urandom_range(1, 24));
        rand_bits(plen, q);
        run_pkt(q, plen, "rand_good");
      end
    end

    jit_mode = 0;
    rand_bits(16, q);
    s0 = n_start;
    send_pkt(q, 16, 8);
    check_eq("abort.started", n_start - s0, 32'd1);
    idle(8);

`ifdef USB_RX_BUS_RESET_EN
    exp_br = 1'b1;
`else
    exp_br = 1'b0;
`endif
    {usb_n_rx, usb_p_rx} = SE0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk_48mhz);
      #1;
      if (n == 122) check_eq("bus_reset.before", {31'd0, bus_reset}, 32'd0);
      if (n == 123) check_eq("bus_reset.rise", {31'd0, bus_reset}, {31'd0, exp_br});
      if (n == 200) check_eq("bus_reset.hold", {31'd0, bus_reset}, {31'd0, exp_br});
    end
    {usb_n_rx, usb_p_rx} = J;
    for (int m = 1; m <= 6; m++) begin
      @(posedge clk_48mhz);
      #1;
      if (m == 3) check_eq("bus_reset.last", {31'd0, bus_reset}, {31'd0, exp_br});
      if (m == 4) check_eq("bus_reset.fall", {31'd0, bus_reset}, 32'd0);
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
